// File: rtl/reg_ctrl_pkg.sv
// Shared opcode encoding, FSM state type and helpers for the register command arbiter.
package reg_ctrl_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP  = 3'd0;
  localparam logic [OP_W-1:0] OP_CLR  = 3'd1;
  localparam logic [OP_W-1:0] OP_LOAD = 3'd2;
  localparam logic [OP_W-1:0] OP_INC  = 3'd3;
  localparam logic [OP_W-1:0] OP_DEC  = 3'd4;
  localparam logic [OP_W-1:0] OP_SHR  = 3'd5;
  localparam logic [OP_W-1:0] OP_SHL  = 3'd6;
  localparam logic [OP_W-1:0] OP_ROR  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // INC and above honour the repeat count; NOP/CLR/LOAD are single-shot.
  function automatic logic op_repeats(input logic [OP_W-1:0] op);
    return op >= OP_INC;
  endfunction

endpackage

// File: rtl/register_cmd_arbiter_if.sv
// Requester-side handshake bundle: per-requester commands in, grant/done/result out.
interface register_cmd_arbiter_if
  import reg_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int CNT_W   = 4
);

  logic [NUM_REQ-1:0]        req;
  logic [OP_W*NUM_REQ-1:0]   req_op;
  logic [DATA_W*NUM_REQ-1:0] req_data;
  logic [CNT_W*NUM_REQ-1:0]  req_cnt;
  logic [NUM_REQ-1:0]        req_fill;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         result;

  modport master (
    output req, req_op, req_data, req_cnt, req_fill,
    input  gnt, done, result
  );

  modport slave (
    input  req, req_op, req_data, req_cnt, req_fill,
    output gnt, done, result
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  int               pos;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      cand = IDX_W'(pos);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/register_cmd_arbiter.sv
// Arbitrates NUM_REQ requesters onto one external control register and sequences
// the winner's command as strobe cycles, then reports the final value with done.
module register_cmd_arbiter
  import reg_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  register_cmd_arbiter_if.slave rif,
  output logic              busy,
  output logic              reg_cl,
  output logic              reg_ld,
  output logic              reg_inc,
  output logic              reg_dec,
  output logic              reg_sr,
  output logic              reg_sl,
  output logic              reg_ir,
  output logic              reg_il,
  output logic [DATA_W-1:0] reg_in,
  input  logic [DATA_W-1:0] reg_q
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state_reg;
  logic [IDX_W-1:0]     ptr_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [OP_W-1:0]      op_reg;
  logic [DATA_W-1:0]    data_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 fill_reg;
  logic [NUM_REQ-1:0]   gnt_reg;
  logic [NUM_REQ-1:0]   done_reg;
  logic [DATA_W-1:0]    result_reg;

  logic [NUM_REQ-1:0]   win_grant;
  logic [IDX_W-1:0]     win_idx;

  logic [OP_W-1:0]      op_slice   [NUM_REQ];
  logic [DATA_W-1:0]    data_slice [NUM_REQ];
  logic [CNT_W-1:0]     cnt_slice  [NUM_REQ];

  logic [OP_W-1:0]      op_sel;
  logic [CNT_W-1:0]     cnt_sel;
  logic                 exec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign op_slice[gi]   = rif.req_op[OP_W*gi +: OP_W];
      assign data_slice[gi] = rif.req_data[DATA_W*gi +: DATA_W];
      assign cnt_slice[gi]  = rif.req_cnt[CNT_W*gi +: CNT_W];
    end
  endgenerate

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req   (rif.req),
    .ptr   (ptr_reg),
    .grant (win_grant),
    .idx   (win_idx)
  );

  assign op_sel  = op_slice[win_idx];
  assign cnt_sel = cnt_slice[win_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      ptr_reg    <= '0;
      idx_reg    <= '0;
      op_reg     <= OP_NOP;
      data_reg   <= '0;
      cnt_reg    <= '0;
      fill_reg   <= 1'b0;
      gnt_reg    <= '0;
      done_reg   <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= '0;
          if (|rif.req) begin
            idx_reg  <= win_idx;
            op_reg   <= op_sel;
            data_reg <= data_slice[win_idx];
            fill_reg <= rif.req_fill[win_idx];
            // Zero repeat count still runs once; single-shot ops force one cycle.
            cnt_reg  <= (op_repeats(op_sel) && cnt_sel != '0) ? cnt_sel : CNT_W'(1);
            gnt_reg  <= win_grant;
            ptr_reg  <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
            state_reg <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_reg <= CNT_W'(1)) begin
            done_reg          <= '0;
            done_reg[idx_reg] <= 1'b1;
            state_reg         <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        ST_DONE: begin
          result_reg <= reg_q;
          done_reg   <= '0;
          gnt_reg    <= '0;
          state_reg  <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobes depend only on the FSM/command flops (ROR also recirculates reg_q[0]).
  assign exec    = (state_reg == ST_EXEC);
  assign reg_cl  = exec && (op_reg == OP_CLR);
  assign reg_ld  = exec && (op_reg == OP_LOAD);
  assign reg_inc = exec && (op_reg == OP_INC);
  assign reg_dec = exec && (op_reg == OP_DEC);
  assign reg_sr  = exec && ((op_reg == OP_SHR) || (op_reg == OP_ROR));
  assign reg_sl  = exec && (op_reg == OP_SHL);
  assign reg_ir  = exec && (((op_reg == OP_SHR) && fill_reg) || ((op_reg == OP_ROR) && reg_q[0]));
  assign reg_il  = exec && (op_reg == OP_SHL) && fill_reg;
  assign reg_in  = (exec && (op_reg == OP_LOAD)) ? data_reg : '0;

  assign busy       = (state_reg != ST_IDLE);
  assign rif.gnt    = gnt_reg;
  assign rif.done   = done_reg;
  assign rif.result = result_reg;

endmodule

// File: tb/tb_register_cmd_arbiter.sv
// Directed bench: drives commands through the arbiter into a behavioural 4-bit register.
module tb_register_cmd_arbiter;
  import reg_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  register_cmd_arbiter_if #(.NUM_REQ(4), .DATA_W(4), .CNT_W(4)) rif ();

  logic       busy;
  logic       reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il;
  logic [3:0] reg_in;
  logic [3:0] reg_q = 4'h0;

  register_cmd_arbiter #(.NUM_REQ(4), .DATA_W(4), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .rif     (rif),
    .busy    (busy),
    .reg_cl  (reg_cl),
    .reg_ld  (reg_ld),
    .reg_inc (reg_inc),
    .reg_dec (reg_dec),
    .reg_sr  (reg_sr),
    .reg_sl  (reg_sl),
    .reg_ir  (reg_ir),
    .reg_il  (reg_il),
    .reg_in  (reg_in),
    .reg_q   (reg_q)
  );

  // External register being controlled.
  always @(posedge clk) begin
    if (reg_cl)       reg_q <= 4'h0;
    else if (reg_ld)  reg_q <= reg_in;
    else if (reg_inc) reg_q <= reg_q + 4'h1;
    else if (reg_dec) reg_q <= reg_q - 4'h1;
    else if (reg_sr)  reg_q <= {reg_ir, reg_q[3:1]};
    else if (reg_sl)  reg_q <= {reg_q[2:0], reg_il};
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl};
  endfunction

  // Issue one command from requester i and follow it through DONE back to IDLE.
  task automatic run_cmd(input int i, input logic [2:0] op, input logic [3:0] d,
                         input logic [3:0] c, input logic f, input int exp_k,
                         input logic [5:0] exp_sb, input logic [3:0] exp_res,
                         input string tag, output logic [3:0] seen_in, output logic seen_ir);
    int cycles, hits, multi;
    @(negedge clk);
    rif.req_op[3*i +: 3]   = op;
    rif.req_data[4*i +: 4] = d;
    rif.req_cnt[4*i +: 4]  = c;
    rif.req_fill[i]        = f;
    rif.req                = 4'(32'(1) << i);
    @(negedge clk);
    rif.req                = '0;
    rif.req_op[3*i +: 3]   = OP_CLR;
    rif.req_data[4*i +: 4] = ~d;
    rif.req_cnt[4*i +: 4]  = 4'hF;
    rif.req_fill[i]        = ~f;
    check_val({tag, " gnt"}, 32'(rif.gnt), 32'(1) << i);
    cycles = 0; hits = 0; multi = 0; seen_in = '0; seen_ir = 1'b0;
    while (rif.done == '0 && cycles < 40) begin
      if (strobes() == exp_sb) hits++;
      if ($countones(strobes()) > 1) multi++;
      if (reg_ld) seen_in = reg_in;
      if (reg_sr) seen_ir = reg_ir;
      cycles++;
      @(negedge clk);
    end
    check_val({tag, " exec_cycles"}, 32'(cycles), 32'(exp_k));
    check_val({tag, " strobe_cycles"}, 32'(hits), 32'(exp_k));
    check_val({tag, " onehot_strobe"}, 32'(multi), 32'd0);
    check_val({tag, " done"}, 32'(rif.done), 32'(1) << i);
    check_val({tag, " gnt_in_done"}, 32'(rif.gnt), 32'(1) << i);
    @(negedge clk);
    check_val({tag, " done_drop"}, 32'(rif.done), 32'd0);
    check_val({tag, " gnt_drop"}, 32'(rif.gnt), 32'd0);
    check_val({tag, " busy_idle"}, 32'(busy), 32'd0);
    check_val({tag, " result"}, 32'(rif.result), 32'(exp_res));
  endtask

  logic [3:0] s_in;
  logic       s_ir;

  initial begin
    rst          = 1'b1;
    rif.req      = 4'b1111;
    rif.req_op   = {OP_LOAD, OP_INC, OP_DEC, OP_SHL};
    rif.req_data = 16'h5A5A;
    rif.req_cnt  = 16'h3333;
    rif.req_fill = 4'b1111;

    repeat (3) @(negedge clk);
    check_val("rst gnt", 32'(rif.gnt), 32'd0);
    check_val("rst done", 32'(rif.done), 32'd0);
    check_val("rst strobes", 32'({strobes(), reg_ir, reg_il}), 32'd0);
    check_val("rst reg_in", 32'(reg_in), 32'd0);
    check_val("rst result", 32'(rif.result), 32'd0);
    check_val("rst busy", 32'(busy), 32'd0);

    rif.req    = '0;
    rif.req_op = '0;
    rif.req_cnt = '0;
    rst        = 1'b0;
    @(negedge clk);

    // All four requesters hold NOP requests; grants rotate from pointer 0.
    rif.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      int w;
      w = 0;
      while (rif.done == '0 && w < 10) begin
        @(negedge clk);
        w++;
      end
      check_val($sformatf("rot%0d done", g), 32'(rif.done), 32'(1) << (g % 4));
      @(negedge clk);
      if (g == 4) rif.req = '0;
      check_val($sformatf("rot%0d pulse", g), 32'(rif.done), 32'd0);
    end
    repeat (2) @(negedge clk);

    run_cmd(2, OP_LOAD, 4'hA, 4'h3, 1'b0, 1, 6'b010000, 4'hA, "load_a", s_in, s_ir);
    check_val("load_a reg_in", 32'(s_in), 32'hA);

    run_cmd(1, OP_LOAD, 4'hE, 4'h0, 1'b0, 1, 6'b010000, 4'hE, "pre_e", s_in, s_ir);
    run_cmd(0, OP_INC, 4'h0, 4'h3, 1'b0, 3, 6'b001000, 4'h1, "inc3_wrap", s_in, s_ir);
    run_cmd(2, OP_INC, 4'h0, 4'h0, 1'b0, 1, 6'b001000, 4'h2, "inc_cnt0", s_in, s_ir);

    run_cmd(3, OP_LOAD, 4'h9, 4'h0, 1'b0, 1, 6'b010000, 4'h9, "pre_9", s_in, s_ir);
    run_cmd(0, OP_ROR, 4'h0, 4'h1, 1'b0, 1, 6'b000010, 4'hC, "ror1", s_in, s_ir);
    check_val("ror1 reg_ir", 32'(s_ir), 32'd1);
    run_cmd(1, OP_SHL, 4'h0, 4'h2, 1'b0, 2, 6'b000001, 4'h0, "shl2", s_in, s_ir);
    run_cmd(2, OP_SHR, 4'h0, 4'h2, 1'b1, 2, 6'b000010, 4'hC, "shr2_fill1", s_in, s_ir);
    run_cmd(3, OP_CLR, 4'h0, 4'h7, 1'b0, 1, 6'b100000, 4'h0, "clr", s_in, s_ir);

    // Reset in the second EXEC cycle of DEC cnt=5; winner 2 would leave pointer at 3.
    run_cmd(1, OP_LOAD, 4'h7, 4'h0, 1'b0, 1, 6'b010000, 4'h7, "pre_7", s_in, s_ir);
    @(negedge clk);
    rif.req_op[8:6]   = OP_DEC;
    rif.req_cnt[11:8] = 4'h5;
    rif.req           = 4'b0100;
    @(negedge clk);
    rif.req = '0;
    check_val("dec exec1 strobe", 32'(strobes()), 32'(6'b000100));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst strobes", 32'({strobes(), reg_ir, reg_il}), 32'd0);
    check_val("midrst done", 32'(rif.done), 32'd0);
    check_val("midrst busy", 32'(busy), 32'd0);
    check_val("midrst gnt", 32'(rif.gnt), 32'd0);
    check_val("midrst reg_q", 32'(reg_q), 32'h5);
    rst               = 1'b0;
    rif.req_op[5:3]   = OP_NOP;
    rif.req_op[11:9]  = OP_NOP;
    rif.req           = 4'b1010;
    @(negedge clk);
    rif.req = '0;
    check_val("post_rst gnt", 32'(rif.gnt), 32'(4'b0010));
    repeat (3) @(negedge clk);
    check_val("post_rst idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
